// File: rtl/image_row_loader.sv
// Assembles 28 seven-bit pixel chunks into one 14x14 image and holds it until acked.
// Ports: clk, rst (sync, active-high), data_in/data_valid/sof (chunk input),
//        image_ack (consumer pulse), image_data/image_ready (assembled image),
//        chunk_count (chunks accepted this frame), overrun (sticky drop flag).
module image_row_loader #(
    parameter int CHUNK_W    = 7,
    parameter int NUM_CHUNKS = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHUNK_W-1:0]            data_in,
    input  logic                          data_valid,
    input  logic                          sof,
    input  logic                          image_ack,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] image_data,
    output logic                          image_ready,
    output logic [4:0]                    chunk_count,
    output logic                          overrun
);

    localparam int IMG_W = CHUNK_W * NUM_CHUNKS;
    localparam logic [4:0] LAST = 5'(NUM_CHUNKS);

    typedef enum logic {
        FILL  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [IMG_W-1:0] data_n;
    logic [4:0]       count_n;
    logic             overrun_n;
    logic [4:0]       slot;

    // A start-of-frame chunk always lands in slot 0, discarding any partial frame.
    assign slot = sof ? 5'd0 : chunk_count;

    // State is a flop, so image_ready is registered and rises the cycle after the last chunk.
    assign image_ready = (state == READY);

    always_comb begin
        state_n   = state;
        data_n    = image_data;
        count_n   = chunk_count;
        overrun_n = overrun;
        unique case (state)
            FILL: begin
                if (data_valid) begin
                    data_n[CHUNK_W*int'(slot) +: CHUNK_W] = data_in;
                    count_n = slot + 5'd1;
                    if (slot + 5'd1 == LAST) begin
                        state_n = READY;
                    end
                end
            end
            READY: begin
                // Ack wins over a coincident chunk; that chunk is dropped silently.
                if (image_ack) begin
                    state_n   = FILL;
                    count_n   = 5'd0;
                    overrun_n = 1'b0;
                end else if (data_valid) begin
                    overrun_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            image_data  <= '0;
            chunk_count <= 5'd0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_n;
            image_data  <= data_n;
            chunk_count <= count_n;
            overrun     <= overrun_n;
        end
    end

endmodule

// File: tb/tb_image_row_loader.sv
// Randomised scoreboard bench for image_row_loader.
// A frame-level model pushes expected images; a monitor pops them on image_ready.
module tb_image_row_loader;

    localparam int CW = 7;
    localparam int NC = 28;
    localparam int IW = CW * NC;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          sof = 1'b0;
    logic          image_ack = 1'b0;
    logic [IW-1:0] image_data;
    logic          image_ready;
    logic [4:0]    chunk_count;
    logic          overrun;

    image_row_loader #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .data_valid(data_valid),
        .sof(sof),
        .image_ack(image_ack),
        .image_data(image_data),
        .image_ready(image_ready),
        .chunk_count(chunk_count),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the chunks of the current frame, the last full image, and flags.
    logic [CW-1:0] frame[$];
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] m_img = '0;
    bit            m_ready = 0;
    bit            m_overrun = 0;

    task automatic chk(input string name, input logic [IW-1:0] act,
                       input logic [IW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        frame.delete();
        m_ready = 0;
        m_overrun = 0;
        m_img = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CW-1:0] d, input bit s);
        data_in = d;
        sof = s;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        sof = 1'b0;
        if (m_ready) begin
            m_overrun = 1;
        end else begin
            if (s) frame.delete();
            frame.push_back(d);
            if (frame.size() == NC) begin
                for (int i = 0; i < NC; i++) m_img[CW*i +: CW] = frame[i];
                exp_q.push_back(m_img);
                m_ready = 1;
                frame.delete();
            end
        end
    endtask

    task automatic ack(input bit with_valid, input logic [CW-1:0] d);
        image_ack = 1'b1;
        data_valid = with_valid;
        data_in = d;
        @(posedge clk);
        #1;
        image_ack = 1'b0;
        data_valid = 1'b0;
        if (m_ready) begin
            m_ready = 0;
            m_overrun = 0;
        end
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_ready"}, IW'(image_ready), IW'(m_ready));
        chk({tag, "_count"}, IW'(chunk_count),
            IW'(m_ready ? NC : frame.size()));
        chk({tag, "_overrun"}, IW'(overrun), IW'(m_overrun));
    endtask

    // Monitor: each rising image_ready must match the next queued image.
    bit prev_ready = 0;
    always @(negedge clk) begin
        if (image_ready && !prev_ready) begin
            chk("mon_pending", IW'(exp_q.size() != 0), IW'(1));
            if (exp_q.size() != 0) begin
                chk("mon_image", image_data, exp_q.pop_front());
                chk("mon_count", IW'(chunk_count), IW'(NC));
            end
        end
        prev_ready = image_ready;
    end

    initial begin
        logic [IW-1:0] snap;
        rst = 1'b1;
        idle(2);
        do_reset();
        chk("rst_data", image_data, '0);
        check_flags("rst");

        // Sequential chunk values; ready must appear right after the last one.
        for (int k = 0; k < NC; k++) begin
            send(CW'(k), 1'b0);
            if (k == NC - 2) chk("ready_early", IW'(image_ready), IW'(0));
        end
        chk("ready_after_last", IW'(image_ready), IW'(1));
        check_flags("seq");

        // Chunks during READY are dropped and flag overrun.
        snap = m_img;
        for (int i = 0; i < 3; i++) send(7'h55, 1'b0);
        chk("ovr_data", image_data, snap);
        check_flags("ovr");
        ack(1'b0, '0);
        check_flags("ovr_ack");

        // Resync: partial frame discarded by sof.
        for (int i = 0; i < 10; i++) send(7'h7F, 1'b0);
        send(7'h01, 1'b1);
        for (int i = 0; i < NC - 1; i++) send(7'h00, 1'b0);
        chk("sof_image", image_data, IW'(1));
        check_flags("sof");

        // Ack together with a chunk: chunk not written, no overrun.
        snap = m_img;
        ack(1'b1, 7'h3C);
        chk("ackv_data", image_data, snap);
        check_flags("ackv");

        // Ack while filling is ignored.
        for (int i = 0; i < 5; i++) send(CW'($urandom), 1'b0);
        ack(1'b0, '0);
        check_flags("fill_ack");

        // Reset mid-frame.
        for (int i = 0; i < 10; i++) send(CW'($urandom), 1'b0);
        do_reset();
        chk("mid_rst_data", image_data, '0);
        check_flags("mid_rst");
        for (int i = 0; i < NC; i++) send(CW'($urandom), 1'b0);
        check_flags("post_rst");
        ack(1'b0, '0);

        // Random frames, with optional gaps and optional resync prefix.
        for (int f = 0; f < 8; f++) begin
            bit gaps;
            gaps = f[0];
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = int'($urandom_range(1, 12));
                for (int i = 0; i < n; i++) send(CW'($urandom), 1'b0);
            end
            for (int i = 0; i < NC; i++) begin
                send(CW'($urandom), i == 0);
                if (gaps && i != NC - 1) begin
                    idle(int'($urandom_range(1, 5)));
                    chk("gap_ready", IW'(image_ready), IW'(0));
                end
            end
            idle(int'($urandom_range(0, 3)));
            check_flags("rnd");
            ack(1'b0, '0);
            check_flags("rnd_ack");
        end

        idle(3);
        chk("queue_drained", IW'(exp_q.size()), IW'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/image_row_loader.md
IMAGE_ROW_LOADER -- requirements
Module: image_row_loader

Interface
REQ-001 SHALL have parameter CHUNK_W, default 7: bits per input chunk, which is half of one 14-pixel image row.
REQ-002 SHALL have parameter NUM_CHUNKS, default 28: chunks per image, giving 14x14 = 196 bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-005 SHALL have port data_in, input, CHUNK_W: pixel chunk; 1 = ink.
REQ-006 SHALL have port data_valid, input, 1: data_in holds a chunk this cycle.
REQ-007 SHALL have port sof, input, 1: start-of-frame marker; qualified by data_valid.
REQ-008 SHALL have port image_ack, input, 1: the consumer has latched image_data; one-cycle pulse.
REQ-009 SHALL have port image_data, output, CHUNK_W*NUM_CHUNKS: assembled image, registered.
REQ-010 SHALL have port image_ready, output, 1: image_data is complete and stable.
REQ-011 SHALL have port chunk_count, output, 5: number of chunks accepted in the current frame, 0..28.
REQ-012 SHALL have port overrun, output, 1: sticky flag; a chunk was dropped while in READY.

Function
REQ-013 SHALL implement a two-state FSM: FILL (accepting chunks) and READY (holding a complete image).
REQ-014 SHALL, in FILL on data_valid=1 with sof=0, write data_in to image_data[CHUNK_W*k +: CHUNK_W] and increment chunk_count, where k = chunk_count.
REQ-015 SHALL, in FILL on data_valid=1 with sof=1, write the chunk to slot 0 and set chunk_count=1, discarding any partial frame (resync).
REQ-016 SHALL, when the chunk accepted in FILL is the 28th (chunk_count goes 27->28), move to READY and assert image_ready in the next cycle, one cycle after that chunk's edge.
REQ-017 SHALL, in FILL with data_valid=0, hold all state.
REQ-018 SHALL, in READY, hold image_data and chunk_count=28 constant.
REQ-019 SHALL, in READY with data_valid=1 and image_ack=0, drop the chunk and set overrun=1.
REQ-020 SHALL, in READY on image_ack=1, go to FILL, set chunk_count=0, deassert image_ready, and clear overrun, all on that edge.
REQ-021 SHALL, when image_ack=1 and data_valid=1 coincide in READY, process the ack and drop the chunk without setting overrun.
REQ-022 SHALL ignore image_ack while in FILL.
REQ-023 SHALL leave stale image_data bits in place after an ack; they are overwritten slot by slot as new chunks arrive.
REQ-024 SHALL map bit j of data_in to image_data[CHUNK_W*k + j]: row r = k/2, column c = 7*(k%2) + j.
REQ-025 SHALL never let chunk_count exceed 28 and never wrap it.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, enter FILL and set image_data=0, image_ready=0, chunk_count=0, overrun=0, overriding all other inputs.
REQ-027 SHALL, if rst is asserted mid-frame or in READY, discard the frame; the next accepted chunk goes to slot 0.

Verification
REQ-028 SHALL cover: reset, then 28 valid chunks with chunk k = k[6:0] -> image_ready=1 one cycle after the last chunk, each slot k equals k, chunk_count=28.
REQ-029 SHALL cover: 10 chunks of 7'h7F, then sof with 7'h01, then 27 chunks of 7'h00 -> image_ready=1 with only image_data[0]=1 set.
REQ-030 SHALL cover: in READY, 3 valid chunks of 7'h55 -> image_data unchanged, overrun=1; then image_ack -> overrun=0, image_ready=0, chunk_count=0.
REQ-031 SHALL cover: image_ack and data_valid in the same cycle in READY -> FILL, chunk_count=0, overrun=0; the chunk is not written.
REQ-032 SHALL cover: rst=1 after 15 chunks -> all outputs 0; a following full 28-chunk frame completes normally.
REQ-033 SHALL cover: data_valid gaps of 1-5 idle cycles between chunks -> same image as gap-free delivery; image_ready only after the 28th chunk.
